// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the MM:SS stopwatch controller.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_LAP   = 2'd3
  } sw_state_e;

  typedef struct packed {
    logic [3:0] min_tens;
    logic [3:0] min_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
  } bcd_time_t;

  localparam logic [3:0] ONES_MAX     = 4'd9;
  localparam logic [3:0] SEC_TENS_MAX = 4'd5;
  localparam logic [3:0] MIN_TENS_MAX = 4'd5;

  function automatic logic is_running(input sw_state_e s);
    return (s == S_RUN) || (s == S_LAP);
  endfunction

endpackage

// File: rtl/stopwatch_controller_if.sv
// Command pulses in, time/status out; slave side is the controller.
interface stopwatch_controller_if;

  logic        start_stop_i;
  logic        lap_i;
  logic        clear_i;
  logic [15:0] live_bcd_o;
  logic [15:0] disp_bcd_o;
  logic        running_o;
  logic        lap_active_o;
  logic        wrap_o;
  logic [1:0]  state_o;

  modport master (
    output start_stop_i, lap_i, clear_i,
    input  live_bcd_o, disp_bcd_o, running_o, lap_active_o, wrap_o, state_o
  );

  modport slave (
    input  start_stop_i, lap_i, clear_i,
    output live_bcd_o, disp_bcd_o, running_o, lap_active_o, wrap_o, state_o
  );

endinterface

// File: rtl/bcd_digit_counter.sv
// One BCD digit of the time chain: counts 0..max_i on en_i, carry when rolling over.
module bcd_digit_counter (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic [3:0] max_i,
  output logic [3:0] digit_o,
  output logic       carry_o
);

  logic [3:0] digit_q;
  logic [3:0] digit_d;

  // Rolling over on ">=" also recovers a corrupted digit to 0 instead of leaving it non-BCD.
  assign carry_o = en_i && (digit_q >= max_i);
  assign digit_o = digit_q;

  always_comb begin
    digit_d = digit_q;
    if (clr_i) begin
      digit_d = 4'd0;
    end else if (en_i) begin
      if (digit_q >= max_i) begin
        digit_d = 4'd0;
      end else begin
        digit_d = digit_q + 4'd1;
      end
    end else begin
      digit_d = digit_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      digit_q <= 4'd0;
    end else begin
      digit_q <= digit_d;
    end
  end

endmodule

// File: rtl/stopwatch_controller.sv
// MM:SS stopwatch with start/stop, clear and (with STOPWATCH_LAP_EN defined) a lap-freeze display.
module stopwatch_controller
  import stopwatch_pkg::*;
#(
  parameter int unsigned TICK_DIV = 50000000
) (
  input  logic                         CLOCK_50_I,
  input  logic                         resetn,
  stopwatch_controller_if.slave        sw
);

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ZERO = {DIV_W{1'b0}};

  sw_state_e        state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             wrap_q;
  logic             running_s;
  logic             tick_s;
  logic             clr_s;
  logic             cmd_clr_s, cmd_ss_s, cmd_lap_s;
  logic [3:0]       carry_s;
  bcd_time_t        time_s;

  // Priority resolution: the highest asserted command wins, the rest are dropped.
  assign cmd_clr_s = sw.clear_i;
  assign cmd_ss_s  = !sw.clear_i && sw.start_stop_i;

  assign running_s = is_running(state_q);
  assign tick_s    = running_s && (div_q == DIV_LAST);

  always_comb begin
    state_d = state_q;
    clr_s   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_ss_s) state_d = S_RUN;
        else          state_d = S_IDLE;
      end
      S_RUN: begin
        if (cmd_ss_s)       state_d = S_PAUSE;
        else if (cmd_lap_s) state_d = S_LAP;
        else                state_d = S_RUN;
      end
      S_LAP: begin
        if (cmd_ss_s)       state_d = S_PAUSE;
        else if (cmd_lap_s) state_d = S_RUN;
        else                state_d = S_LAP;
      end
      S_PAUSE: begin
        if (cmd_clr_s) begin
          state_d = S_IDLE;
          clr_s   = 1'b1;
        end else if (cmd_ss_s) begin
          state_d = S_RUN;
        end else begin
          state_d = S_PAUSE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Divider keeps the partial second across PAUSE so resuming finishes that second.
  always_comb begin
    div_d = div_q;
    if (clr_s) begin
      div_d = DIV_ZERO;
    end else if (running_s) begin
      if (tick_s) div_d = DIV_ZERO;
      else        div_d = div_q + DIV_W'(1);
    end else if (state_q == S_PAUSE) begin
      div_d = div_q;
    end else begin
      div_d = DIV_ZERO;
    end
  end

  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      div_q   <= DIV_ZERO;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      wrap_q  <= carry_s[3];
    end
  end

  bcd_digit_counter u_sec_ones (
    .clk_i(CLOCK_50_I), .rst_ni(resetn), .clr_i(clr_s), .en_i(tick_s),
    .max_i(ONES_MAX), .digit_o(time_s.sec_ones), .carry_o(carry_s[0])
  );

  bcd_digit_counter u_sec_tens (
    .clk_i(CLOCK_50_I), .rst_ni(resetn), .clr_i(clr_s), .en_i(carry_s[0]),
    .max_i(SEC_TENS_MAX), .digit_o(time_s.sec_tens), .carry_o(carry_s[1])
  );

  bcd_digit_counter u_min_ones (
    .clk_i(CLOCK_50_I), .rst_ni(resetn), .clr_i(clr_s), .en_i(carry_s[1]),
    .max_i(ONES_MAX), .digit_o(time_s.min_ones), .carry_o(carry_s[2])
  );

  bcd_digit_counter u_min_tens (
    .clk_i(CLOCK_50_I), .rst_ni(resetn), .clr_i(clr_s), .en_i(carry_s[2]),
    .max_i(MIN_TENS_MAX), .digit_o(time_s.min_tens), .carry_o(carry_s[3])
  );

`ifdef STOPWATCH_LAP_EN
  bcd_time_t lap_q, lap_d;

  assign cmd_lap_s = !sw.clear_i && !sw.start_stop_i && sw.lap_i;

  // Lap register snapshots the time shown just before the RUN->LAP edge.
  always_comb begin
    lap_d = lap_q;
    if (clr_s) begin
      lap_d = bcd_time_t'(16'h0000);
    end else if ((state_q == S_RUN) && cmd_lap_s) begin
      lap_d = time_s;
    end else begin
      lap_d = lap_q;
    end
  end

  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      lap_q <= bcd_time_t'(16'h0000);
    end else begin
      lap_q <= lap_d;
    end
  end

  assign sw.disp_bcd_o = (state_q == S_LAP) ? lap_q : time_s;
`else
  logic unused_lap_s;

  assign unused_lap_s  = sw.lap_i;
  assign cmd_lap_s     = 1'b0;
  assign sw.disp_bcd_o = time_s;
`endif

  assign sw.live_bcd_o   = time_s;
  assign sw.running_o    = running_s;
  assign sw.lap_active_o = (state_q == S_LAP);
  assign sw.wrap_o       = wrap_q;
  assign sw.state_o      = state_q;

endmodule

// File: tb/tb_stopwatch_controller.sv
// Directed + random bench for stopwatch_controller against a seconds-count reference model.
module tb_stopwatch_controller;

  localparam int unsigned TICK_DIV = 4;
`ifdef STOPWATCH_LAP_EN
  localparam bit LAP_EN = 1'b1;
`else
  localparam bit LAP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  stopwatch_controller_if sw_if ();

  stopwatch_controller #(.TICK_DIV(TICK_DIV)) dut (
    .CLOCK_50_I(clk),
    .resetn    (resetn),
    .sw        (sw_if)
  );

  int n_cmp;
  int n_err;
  int wraps;

  // Reference model: state as 0=idle 1=run 2=pause 3=lap, time as total seconds.
  int m_state, m_secs, m_div, m_lap;
  bit m_wrap;

  function automatic logic [15:0] to_bcd(input int s);
    int mm, ss;
    mm = s / 60;
    ss = s % 60;
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  task automatic model_reset();
    m_state = 0; m_secs = 0; m_div = 0; m_lap = 0; m_wrap = 1'b0;
  endtask

  task automatic model_step(input bit ss, input bit lap, input bit clr);
    bit run, tick, c_clr, c_ss, c_lap;
    int ns, nsec, ndiv, nlap;
    run   = (m_state == 1) || (m_state == 3);
    tick  = run && (m_div == int'(TICK_DIV) - 1);
    nsec  = tick ? (m_secs + 1) % 3600 : m_secs;
    ndiv  = run ? (m_div + 1) % int'(TICK_DIV) : ((m_state == 2) ? m_div : 0);
    nlap  = m_lap;
    ns    = m_state;
    c_clr = clr;
    c_ss  = !clr && ss;
    c_lap = !clr && !ss && lap && LAP_EN;
    if (m_state == 0) begin
      if (c_ss) ns = 1;
    end else if (m_state == 1) begin
      if (c_ss) ns = 2;
      else if (c_lap) begin ns = 3; nlap = m_secs; end
    end else if (m_state == 3) begin
      if (c_ss) ns = 2;
      else if (c_lap) ns = 1;
    end else begin
      if (c_clr) begin ns = 0; nsec = 0; ndiv = 0; nlap = 0; end
      else if (c_ss) ns = 1;
    end
    m_wrap  = tick && (m_secs == 3599);
    m_state = ns; m_secs = nsec; m_div = ndiv; m_lap = nlap;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    bit run;
    run = (m_state == 1) || (m_state == 3);
    check({tag, "_live"}, sw_if.live_bcd_o, to_bcd(m_secs));
    check({tag, "_disp"}, sw_if.disp_bcd_o, (m_state == 3) ? to_bcd(m_lap) : to_bcd(m_secs));
    check({tag, "_running"}, 16'(sw_if.running_o), 16'(run));
    check({tag, "_lapact"}, 16'(sw_if.lap_active_o), 16'(m_state == 3));
    check({tag, "_wrap"}, 16'(sw_if.wrap_o), 16'(m_wrap));
    check({tag, "_state"}, 16'(sw_if.state_o), 16'(m_state));
  endtask

  task automatic step(input bit ss, input bit lap, input bit clr, input bit chk);
    @(negedge clk);
    sw_if.start_stop_i = ss;
    sw_if.lap_i        = lap;
    sw_if.clear_i      = clr;
    @(posedge clk);
    model_step(ss, lap, clr);
    #1;
    sw_if.start_stop_i = 1'b0;
    sw_if.lap_i        = 1'b0;
    sw_if.clear_i      = 1'b0;
    if (chk) check_all("step");
  endtask

  initial begin
    int r;
    n_cmp = 0;
    n_err = 0;
    sw_if.start_stop_i = 1'b0;
    sw_if.lap_i        = 1'b0;
    sw_if.clear_i      = 1'b0;
    resetn = 1'b1;
    model_reset();
    #2 resetn = 1'b0;
    #10;
    check_all("reset");
    @(negedge clk) resetn = 1'b1;

    // Start and run ten seconds.
    step(1'b1, 1'b0, 1'b0, 1'b1);
    repeat (40) step(1'b0, 1'b0, 1'b0, 1'b1);
    check("run10_live", sw_if.live_bcd_o, 16'h0010);
    check("run10_running", 16'(sw_if.running_o), 16'h0001);

    // Pause mid-second, hold, resume: increment two cycles after resume.
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    repeat (20) step(1'b0, 1'b0, 1'b0, 1'b1);
    check("pause_held", sw_if.live_bcd_o, 16'h0010);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("resume_c1", sw_if.live_bcd_o, 16'h0010);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("resume_c2", sw_if.live_bcd_o, 16'h0011);

    // Lap at 00:07.
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    check("clear_live", sw_if.live_bcd_o, 16'h0000);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    repeat (28) step(1'b0, 1'b0, 1'b0, 1'b1);
    check("at7_live", sw_if.live_bcd_o, 16'h0007);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    repeat (12) step(1'b0, 1'b0, 1'b0, 1'b1);
    check("lap_live", sw_if.live_bcd_o, 16'h0010);
    check("lap_disp", sw_if.disp_bcd_o, LAP_EN ? 16'h0007 : 16'h0010);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    check("unlap_disp", sw_if.disp_bcd_o, 16'h0010);
    check("unlap_state", 16'(sw_if.state_o), 16'h0001);

    // Roll over from 59:58.
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    repeat (3598 * TICK_DIV) step(1'b0, 1'b0, 1'b0, 1'b0);
    check_all("ff");
    check("at5958_live", sw_if.live_bcd_o, 16'h5958);
    wraps = 0;
    for (int i = 0; i < 9; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1);
      if (sw_if.wrap_o === 1'b1) wraps++;
    end
    check("wrap_count", 16'(wraps), 16'h0001);
    check("wrap_live", sw_if.live_bcd_o, 16'h0000);
    check("wrap_state", 16'(sw_if.state_o), 16'h0001);

    // Clear with start_stop in PAUSE, clear alone in RUN.
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    check("clrss_state", 16'(sw_if.state_o), 16'h0000);
    check("clrss_disp", sw_if.disp_bcd_o, 16'h0000);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    repeat (6) step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    check("runclr_state", 16'(sw_if.state_o), 16'h0001);
    check("runclr_live", sw_if.live_bcd_o, 16'h0001);

    // Random command traffic against the model.
    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(0, 15));
      if (r == 0)      step(1'b1, 1'b0, 1'b0, 1'b1);
      else if (r == 1) step(1'b0, 1'b1, 1'b0, 1'b1);
      else if (r == 2) step(1'b0, 1'b0, 1'b1, 1'b1);
      else if (r == 3) step(1'b1, 1'b0, 1'b1, 1'b1);
      else if (r == 4) step(1'b1, 1'b1, 1'b0, 1'b1);
      else             step(1'b0, 1'b0, 1'b0, 1'b1);
    end

    // Asynchronous reset mid-second while in LAP (RUN without lap support).
    @(negedge clk) resetn = 1'b0;
    model_reset();
    #1 check_all("rst1");
    @(negedge clk) resetn = 1'b1;
    step(1'b1, 1'b0, 1'b0, 1'b1);
    repeat (5) step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("prerst_lapact", 16'(sw_if.lap_active_o), 16'(LAP_EN));
    #2 resetn = 1'b0;
    model_reset();
    #1 check_all("rst_mid");
    @(negedge clk) resetn = 1'b1;

    // First increment lands exactly TICK_DIV cycles after start.
    step(1'b1, 1'b0, 1'b0, 1'b1);
    repeat (TICK_DIV - 1) step(1'b0, 1'b0, 1'b0, 1'b1);
    check("first_pre", sw_if.live_bcd_o, 16'h0000);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("first_inc", sw_if.live_bcd_o, 16'h0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/stopwatch_controller.md
STOPWATCH_CONTROLLER -- requirements
Module: stopwatch_controller

Interface
REQ-001 Parameter TICK_DIV, default 50000000, is the number of clock cycles per one-second tick (minimum 2).
REQ-002 CLOCK_50_I  input  1  system clock; every flop updates on its rising edge.
REQ-003 resetn  input  1  asynchronous, active-low reset.
REQ-004 start_stop_i  input  1  single-cycle command pulse from the upstream edge detector.
REQ-005 lap_i  input  1  single-cycle lap command pulse.
REQ-006 clear_i  input  1  single-cycle clear command pulse.
REQ-007 live_bcd_o  output  16  running time as {min_tens, min_ones, sec_tens, sec_ones}, each digit 4-bit BCD.
REQ-008 disp_bcd_o  output  16  value the 7-segment display shows: live time or the frozen lap time.
REQ-009 running_o  output  1  high in RUN and LAP.
REQ-010 lap_active_o  output  1  high in LAP.
REQ-011 wrap_o  output  1  one-cycle pulse when the time rolls over from 59:59 to 00:00.
REQ-012 state_o  output  2  encoded FSM state.

Function
REQ-013 The FSM SHALL use four states: IDLE=0, RUN=1, PAUSE=2, LAP=3.
REQ-014 Command priority within a cycle SHALL be clear_i > start_stop_i > lap_i; lower-priority commands in the same cycle are dropped.
REQ-015 IDLE: start_stop_i moves to RUN; lap_i and clear_i are ignored.
REQ-016 RUN: start_stop_i moves to PAUSE; lap_i moves to LAP and latches live_bcd_o into the lap register in the same edge; clear_i is ignored.
REQ-017 LAP: lap_i moves to RUN; start_stop_i moves to PAUSE; clear_i is ignored.
REQ-018 PAUSE: start_stop_i moves to RUN; clear_i moves to IDLE and zeroes the time, the lap register and the divider.
REQ-019 The tick divider SHALL count 0..TICK_DIV-1 in RUN and LAP only.
REQ-020 The divider SHALL hold its value in PAUSE (the partial second is preserved) and be held at 0 in IDLE.
REQ-021 A tick SHALL occur in the cycle the divider equals TICK_DIV-1; the time increments on that same clock edge.
REQ-022 With no pause, the first increment after entering RUN from IDLE SHALL occur exactly TICK_DIV cycles after the start_stop_i edge.
REQ-023 Time arithmetic: sec_ones 0-9, carrying into sec_tens 0-5, carrying into min_ones 0-9, carrying into min_tens 0-5; no digit may ever hold a non-BCD value.
REQ-024 A tick at 59:59 SHALL give 00:00 and a wrap_o pulse of exactly one cycle; the FSM state is unchanged.
REQ-025 disp_bcd_o SHALL equal the lap register in LAP and live_bcd_o in every other state.
REQ-026 All outputs SHALL be registered or decoded from registered state only, with no combinational path from any input.

Reset
REQ-027 When resetn is low: state IDLE, all time digits, lap register and divider at 0, running_o=0, lap_active_o=0, wrap_o=0.
REQ-028 Reset asserted in any state, including mid-second, SHALL take effect immediately and discard any pending tick.

Configuration
REQ-029 With the macro STOPWATCH_LAP_EN defined: LAP state, lap register and lap_i behave as in REQ-016, REQ-017 and REQ-025.
REQ-030 Without STOPWATCH_LAP_EN: no lap register is built, lap_i is ignored, LAP is unreachable, lap_active_o=0, and disp_bcd_o=live_bcd_o.

Structure
REQ-031 Package stopwatch_pkg SHALL hold the state enum typedef, a bcd_time_t packed struct of four 4-bit digits, and the constants SEC_TENS_MAX=5 and MIN_TENS_MAX=5.
REQ-032 A sub-module bcd_digit_counter (inputs enable and max value; outputs digit and carry) SHALL be instantiated four times as a ripple chain.

Verification (TICK_DIV=4)
REQ-033 Reset, start_stop_i, then 40 cycles -> live_bcd_o=16'h0010 and running_o=1.
REQ-034 Pause after 2 cycles of a second, wait 20 cycles, then resume -> the next increment arrives 2 cycles after resume and the time is unchanged while paused.
REQ-035 At 00:07, lap_i, then 12 cycles -> disp_bcd_o=16'h0007 and live_bcd_o=16'h0010; lap_i again -> disp_bcd_o=live_bcd_o on the next cycle.
REQ-036 From 59:58, run 8 cycles -> live_bcd_o=16'h0000 and one wrap_o pulse observed.
REQ-037 In PAUSE, clear_i together with start_stop_i -> state IDLE and all outputs 0; in RUN, clear_i alone -> no effect.
REQ-038 resetn low mid-count in LAP -> all outputs at reset values in the same cycle; build without STOPWATCH_LAP_EN -> lap_i never changes state_o.
